// File: rtl/score_lives_keeper.sv
// Score, lives and coin bookkeeping for a maze chase game.
// Tracks BCD score, coins left, lives and the game FSM.
//
// Ports:
//   clk          : single system clock
//   reset        : synchronous reset, active-high
//   startOfFrame : one-cycle pulse at each frame start
//   coin_pulse   : one-cycle pulse per coin eaten
//   monster_hit  : level, pacman overlaps a monster this cycle
//   stop_gameN   : low freezes counters and FSM (new_game still honoured)
//   new_game     : one-cycle pulse, starts a new game
//   score_bcd    : three BCD digits, [11:8] hundreds
//   lives        : remaining lives
//   coins_left   : coins still on the maze
//   death_pulse  : one-cycle pulse per accepted monster hit
//   invuln       : high in GRACE
//   win          : high in WON
//   lose         : high in LOST
module score_lives_keeper #(
  parameter int unsigned TOTAL_COINS  = 64,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned GRACE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        coin_pulse,
  input  logic        monster_hit,
  input  logic        stop_gameN,
  input  logic        new_game,
  output logic [11:0] score_bcd,
  output logic [1:0]  lives,
  output logic [7:0]  coins_left,
  output logic        death_pulse,
  output logic        invuln,
  output logic        win,
  output logic        lose
);

  localparam logic [7:0] COINS_INIT = 8'(TOTAL_COINS);
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam logic [7:0] GRACE_LAST = 8'(GRACE_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    GRACE = 3'd2,
    WON   = 3'd3,
    LOST  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  coins_q, coins_d;
  logic [7:0]  grace_q, grace_d;
  logic        death_q, death_d;
  logic        prev_q, prev_d;
  logic        taken_q, taken_d;

  logic        rise;
  logic        hit_evt;
  logic        active;
  logic        coin_ok;
  logic        last_coin;

  // Saturating three-digit BCD increment.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    d0 = v[3:0];
    d1 = v[7:4];
    d2 = v[11:8];
    if (v == 12'h999) begin
      return v;
    end
    if (d0 != 4'd9) begin
      d0 = d0 + 4'd1;
    end else begin
      d0 = 4'd0;
      if (d1 != 4'd9) begin
        d1 = d1 + 4'd1;
      end else begin
        d1 = 4'd0;
        d2 = d2 + 4'd1;
      end
    end
    return {d2, d1, d0};
  endfunction

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    coins_d = coins_q;
    grace_d = grace_q;
    death_d = 1'b0;

    // One hit event per frame: a rising edge is accepted only if none
    // was taken yet this frame, or the frame restarts in this cycle.
    rise    = monster_hit & ~prev_q;
    hit_evt = rise & (~taken_q | startOfFrame);
    prev_d  = monster_hit;
    taken_d = hit_evt | (taken_q & ~startOfFrame);

    active    = stop_gameN &
                ((state_q == PLAY) | (state_q == GRACE));
    coin_ok   = active & coin_pulse & (coins_q != 8'd0);
    last_coin = coin_ok & (coins_q == 8'd1);

    if (new_game) begin
      score_d = 12'h000;
      lives_d = LIVES_INIT;
      coins_d = COINS_INIT;
      grace_d = 8'd0;
      state_d = PLAY;
    end else if (active) begin
      if (coin_ok) begin
        coins_d = coins_q - 8'd1;
        score_d = bcd_inc(score_q);
      end
      // The coin goes first; eating the last one wins outright and
      // swallows a simultaneous hit.
      if (last_coin) begin
        state_d = WON;
      end else if ((state_q == PLAY) && hit_evt) begin
        lives_d = lives_q - 2'd1;
        death_d = 1'b1;
        grace_d = 8'd0;
        state_d = (lives_q == 2'd1) ? LOST : GRACE;
      end else if ((state_q == GRACE) && startOfFrame) begin
        if (grace_q == GRACE_LAST) begin
          grace_d = 8'd0;
          state_d = PLAY;
        end else begin
          grace_d = grace_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      score_q <= 12'h000;
      lives_q <= LIVES_INIT;
      coins_q <= COINS_INIT;
      grace_q <= 8'd0;
      death_q <= 1'b0;
      prev_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      coins_q <= coins_d;
      grace_q <= grace_d;
      death_q <= death_d;
      prev_q  <= prev_d;
      taken_q <= taken_d;
    end
  end

  assign score_bcd   = score_q;
  assign lives       = lives_q;
  assign coins_left  = coins_q;
  assign death_pulse = death_q;
  assign invuln      = (state_q == GRACE);
  assign win         = (state_q == WON);
  assign lose        = (state_q == LOST);

endmodule

// File: tb/tb_score_lives_keeper.sv
// Self-checking bench for score_lives_keeper.
// Directed scenarios plus random traffic against a game-level model.
module tb_score_lives_keeper;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sof = 1'b0;
  logic        coin = 1'b0;
  logic        mhit = 1'b0;
  logic        stop_n = 1'b1;
  logic        ng = 1'b0;

  logic [11:0] score_bcd;
  logic [1:0]  lives;
  logic [7:0]  coins_left;
  logic        death_pulse, invuln, win, lose;

  logic [11:0] b_score;
  logic [1:0]  b_lives;
  logic [7:0]  b_coins;
  logic        b_death, b_invuln, b_win, b_lose;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  score_lives_keeper dut (
    .clk(clk), .reset(reset), .startOfFrame(sof),
    .coin_pulse(coin), .monster_hit(mhit),
    .stop_gameN(stop_n), .new_game(ng),
    .score_bcd(score_bcd), .lives(lives),
    .coins_left(coins_left), .death_pulse(death_pulse),
    .invuln(invuln), .win(win), .lose(lose)
  );

  score_lives_keeper #(.TOTAL_COINS(200)) big (
    .clk(clk), .reset(reset), .startOfFrame(sof),
    .coin_pulse(coin), .monster_hit(mhit),
    .stop_gameN(stop_n), .new_game(ng),
    .score_bcd(b_score), .lives(b_lives),
    .coins_left(b_coins), .death_pulse(b_death),
    .invuln(b_invuln), .win(b_win), .lose(b_lose)
  );

  // Game-level model: score as a plain integer, mode as a name.
  typedef enum {M_IDLE, M_PLAY, M_GRACE, M_WON, M_LOST} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_score = 0;
  int    m_lives = 3;
  int    m_coins = 64;
  int    m_frames = 0;
  bit    m_death = 0;
  bit    m_prev = 0;
  bit    m_taken = 0;

  function automatic logic [11:0] to_bcd(input int s);
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic model_step();
    bit hit;
    bit won;
    hit = mhit && !m_prev && (!m_taken || sof);
    m_death = 0;
    if (reset) begin
      m_mode = M_IDLE; m_score = 0; m_lives = 3;
      m_coins = 64; m_frames = 0; m_prev = 0; m_taken = 0;
      return;
    end
    m_prev = mhit;
    m_taken = hit || (m_taken && !sof);
    if (ng) begin
      m_mode = M_PLAY; m_score = 0; m_lives = 3;
      m_coins = 64; m_frames = 0;
    end else if (stop_n &&
                 (m_mode == M_PLAY || m_mode == M_GRACE)) begin
      won = 0;
      if (coin && m_coins > 0) begin
        m_coins--;
        m_score = (m_score + 1 > 999) ? 999 : m_score + 1;
        if (m_coins == 0) begin
          m_mode = M_WON;
          won = 1;
        end
      end
      if (!won && m_mode == M_PLAY && hit) begin
        m_lives--;
        m_death = 1;
        m_frames = 0;
        m_mode = (m_lives > 0) ? M_GRACE : M_LOST;
      end else if (!won && m_mode == M_GRACE && sof) begin
        m_frames++;
        if (m_frames == 60) begin
          m_frames = 0;
          m_mode = M_PLAY;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic coin_once();
    coin = 1'b1; tick(); coin = 1'b0; tick();
  endtask

  task automatic frame_once();
    sof = 1'b1; tick(); sof = 1'b0; tick(); tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; ng = 1'b1; tick(); reset = 1'b0; ng = 1'b0;
    n_checks++;
    if (score_bcd !== 12'h000) begin
      n_fail++; $display("FAIL reset_score got %h want 000", score_bcd);
    end
    n_checks++;
    if (lives !== 2'd3) begin
      n_fail++; $display("FAIL reset_lives got %0d want 3", lives);
    end
    n_checks++;
    if (coins_left !== 8'd64) begin
      n_fail++; $display("FAIL reset_coins got %0d want 64", coins_left);
    end
    n_checks++;
    if ({death_pulse, invuln, win, lose} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000",
               {death_pulse, invuln, win, lose});
    end
  endtask

  task automatic test_coins();
    ng = 1'b1; tick(); ng = 1'b0;
    n_checks++;
    if (coins_left !== 8'd64 || invuln !== 1'b0) begin
      n_fail++; $display("FAIL new_game_load got coins %0d invuln %b want 64 0",
                         coins_left, invuln);
    end
    for (int i = 0; i < 12; i++) coin_once();
    n_checks++;
    if (score_bcd !== 12'h012) begin
      n_fail++; $display("FAIL coins_score got %h want 012", score_bcd);
    end
    n_checks++;
    if (coins_left !== 8'd52) begin
      n_fail++; $display("FAIL coins_left got %0d want 52", coins_left);
    end
    n_checks++;
    if ({invuln, win, lose} !== 3'b000) begin
      n_fail++; $display("FAIL coins_play got %b want 000", {invuln, win, lose});
    end
  endtask

  task automatic test_hit_grace();
    int deaths;
    deaths = 0;
    mhit = 1'b1; tick();
    n_checks++;
    if (death_pulse !== 1'b1 || lives !== 2'd2 || invuln !== 1'b1) begin
      n_fail++;
      $display("FAIL first_hit got death %b lives %0d invuln %b want 1 2 1",
               death_pulse, lives, invuln);
    end
    for (int k = 1; k <= 60; k++) begin
      sof = 1'b1; tick(); deaths += int'(death_pulse);
      sof = 1'b0;
      for (int c = 0; c < 3; c++) begin
        tick(); deaths += int'(death_pulse);
      end
      if (k == 3) mhit = 1'b0;
      if (k == 30) mhit = 1'b1;
      if (k == 59) begin
        n_checks++;
        if (invuln !== 1'b1) begin
          n_fail++; $display("FAIL grace_59 got invuln %b want 1", invuln);
        end
      end
    end
    n_checks++;
    if (deaths != 0 || lives !== 2'd2) begin
      n_fail++; $display("FAIL grace_ignore got deaths %0d lives %0d want 0 2",
                         deaths, lives);
    end
    n_checks++;
    if ({invuln, win, lose} !== 3'b000) begin
      n_fail++; $display("FAIL grace_end got %b want 000", {invuln, win, lose});
    end
  endtask

  task automatic test_lose();
    mhit = 1'b0; tick(); frame_once();
    mhit = 1'b1; tick(); mhit = 1'b0;
    n_checks++;
    if (lives !== 2'd1 || invuln !== 1'b1 || death_pulse !== 1'b1) begin
      n_fail++; $display("FAIL second_hit got lives %0d invuln %b want 1 1",
                         lives, invuln);
    end
    sof = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    sof = 1'b0; tick();
    frame_once();
    mhit = 1'b1; tick(); mhit = 1'b0;
    n_checks++;
    if (lives !== 2'd0 || lose !== 1'b1 || death_pulse !== 1'b1) begin
      n_fail++; $display("FAIL third_hit got lives %0d lose %b death %b want 0 1 1",
                         lives, lose, death_pulse);
    end
    for (int i = 0; i < 3; i++) coin_once();
    n_checks++;
    if (score_bcd !== 12'h012 || coins_left !== 8'd52 || lose !== 1'b1) begin
      n_fail++; $display("FAIL lost_hold got score %h coins %0d want 012 52",
                         score_bcd, coins_left);
    end
  endtask

  task automatic test_last_coin();
    ng = 1'b1; tick(); ng = 1'b0;
    for (int i = 0; i < 63; i++) coin_once();
    frame_once();
    n_checks++;
    if (coins_left !== 8'd1) begin
      n_fail++; $display("FAIL one_left got %0d want 1", coins_left);
    end
    coin = 1'b1; mhit = 1'b1; tick(); coin = 1'b0;
    n_checks++;
    if (win !== 1'b1 || lives !== 2'd3 || death_pulse !== 1'b0) begin
      n_fail++; $display("FAIL last_coin got win %b lives %0d death %b want 1 3 0",
                         win, lives, death_pulse);
    end
    n_checks++;
    if (score_bcd !== 12'h064 || coins_left !== 8'd0) begin
      n_fail++; $display("FAIL last_coin_score got %h %0d want 064 0",
                         score_bcd, coins_left);
    end
    mhit = 1'b0; tick();
    coin_once();
    n_checks++;
    if (coins_left !== 8'd0 || score_bcd !== 12'h064 || win !== 1'b1) begin
      n_fail++; $display("FAIL won_hold got %h %0d want 064 0",
                         score_bcd, coins_left);
    end
  endtask

  task automatic test_stop_and_reset();
    ng = 1'b1; tick(); ng = 1'b0;
    stop_n = 1'b0;
    for (int i = 0; i < 5; i++) coin_once();
    frame_once();
    mhit = 1'b1; tick(); tick();
    n_checks++;
    if (coins_left !== 8'd64 || score_bcd !== 12'h000 ||
        lives !== 2'd3 || invuln !== 1'b0) begin
      n_fail++; $display("FAIL stopped got coins %0d score %h lives %0d want 64 000 3",
                         coins_left, score_bcd, lives);
    end
    mhit = 1'b0; stop_n = 1'b1; tick();
    frame_once();
    mhit = 1'b1; tick(); mhit = 1'b0;
    n_checks++;
    if (invuln !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_grace got invuln %b want 1", invuln);
    end
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++;
    if (score_bcd !== 12'h000 || lives !== 2'd3 || coins_left !== 8'd64 ||
        {death_pulse, invuln, win, lose} !== 4'b0000) begin
      n_fail++; $display("FAIL grace_reset got %h %0d %0d %b",
                         score_bcd, lives, coins_left,
                         {death_pulse, invuln, win, lose});
    end
  endtask

  task automatic test_carry();
    ng = 1'b1; tick(); ng = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      coin_once();
      if (i == 99) begin
        n_checks++;
        if (b_score !== 12'h099) begin
          n_fail++; $display("FAIL carry_99 got %h want 099", b_score);
        end
      end
    end
    n_checks++;
    if (b_score !== 12'h100 || b_coins !== 8'd100) begin
      n_fail++; $display("FAIL carry_100 got %h %0d want 100 100",
                         b_score, b_coins);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    ng = 1'b1; tick(); ng = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom % 300) == 0;
      ng     = ($urandom % 80) == 0;
      sof    = ($urandom % 5) == 0;
      coin   = ($urandom % 3) == 0;
      stop_n = ($urandom % 10) != 0;
      if (($urandom % 6) == 0) mhit = ~mhit;
      tick();
      n_checks++;
      if (score_bcd !== to_bcd(m_score) || lives !== 2'(m_lives) ||
          coins_left !== 8'(m_coins) || death_pulse !== m_death ||
          invuln !== (m_mode == M_GRACE) || win !== (m_mode == M_WON) ||
          lose !== (m_mode == M_LOST)) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random cyc %0d got %h %0d %0d %b%b%b%b want %h %0d %0d %b mode %s",
                   i, score_bcd, lives, coins_left, death_pulse, invuln, win,
                   lose, to_bcd(m_score), m_lives, m_coins, m_death,
                   m_mode.name());
        bad++;
      end
    end
    reset = 1'b0; ng = 1'b0; sof = 1'b0; coin = 1'b0;
    mhit = 1'b0; stop_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_coins();
    test_hit_grace();
    test_lose();
    test_last_coin();
    test_stop_and_reset();
    test_carry();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_lives_keeper.md
SCORE_LIVES_KEEPER -- requirements
Module: score_lives_keeper

Interface
REQ-001 Parameter TOTAL_COINS, default 64, meaning number of coins on the maze (1..255).
REQ-002 Parameter START_LIVES, default 3, meaning lives at game start (1..3).
REQ-003 Parameter GRACE_FRAMES, default 60, meaning invulnerability length in frames after a death (1..255).
REQ-004 clk  in  1  system clock; the block uses this single clock only.
REQ-005 reset  in  1  synchronous reset, active-high.
REQ-006 startOfFrame  in  1  one-cycle pulse at each frame start.
REQ-007 coin_pulse  in  1  one-cycle pulse per coin eaten.
REQ-008 monster_hit  in  1  level; pacman/monster overlap this cycle.
REQ-009 stop_gameN  in  1  low = game halted; freezes all counters.
REQ-010 new_game  in  1  one-cycle pulse; starts a new game from IDLE, WON or LOST.
REQ-011 score_bcd  out  12  three BCD digits, [11:8] hundreds.
REQ-012 lives  out  2  remaining lives.
REQ-013 coins_left  out  8  coins still on the maze.
REQ-014 death_pulse  out  1  one-cycle pulse per accepted monster hit.
REQ-015 invuln  out  1  high while in GRACE.
REQ-016 win  out  1  high while in WON.
REQ-017 lose  out  1  high while in LOST.

Function
REQ-018 The FSM SHALL have the states IDLE, PLAY, GRACE, WON and LOST.
REQ-019 On new_game, the block SHALL load score=000, lives=START_LIVES and coins_left=TOTAL_COINS, then enter PLAY on the next cycle.
REQ-020 In PLAY or GRACE with stop_gameN=1, a coin_pulse SHALL decrement coins_left and BCD-increment score by 1, one cycle after the pulse.
REQ-021 BCD increment SHALL carry digit 9->0 into the next digit.
REQ-022 Score SHALL saturate at 999.
REQ-023 When coins_left decrements to 0, the FSM SHALL enter WON in the same update.
REQ-024 coin_pulse SHALL be ignored when coins_left is already 0.
REQ-025 A hit event SHALL be defined as a rising edge of monster_hit (registered previous value), at most one per frame.
REQ-026 The per-frame semaphore SHALL clear on startOfFrame.
REQ-027 In PLAY, a hit event SHALL decrement lives and assert death_pulse for one cycle.
REQ-028 After a hit in PLAY, the FSM SHALL enter GRACE if the new lives value is >0, otherwise LOST.
REQ-029 In GRACE, hit events SHALL be ignored with no death_pulse and no lives change.
REQ-030 GRACE SHALL count startOfFrame pulses and return to PLAY after GRACE_FRAMES pulses.
REQ-031 When a coin and a hit occur in the same cycle, the coin SHALL be processed first.
REQ-032 If that coin is the last one, the result SHALL be WON and the hit SHALL be ignored.
REQ-033 While stop_gameN=0, all counters and the FSM SHALL hold, except that new_game is still honoured.
REQ-034 In WON and LOST, coin_pulse and hit events SHALL be ignored and all outputs SHALL hold.
REQ-035 new_game SHALL have priority over all other events in the same cycle.
REQ-036 All outputs SHALL be registered.
REQ-037 win, lose and invuln SHALL decode directly from the state register.

Reset
REQ-038 When reset=1 at a clk edge, the FSM SHALL enter IDLE.
REQ-039 On reset, outputs SHALL be: score_bcd=000, lives=START_LIVES, coins_left=TOTAL_COINS, death_pulse=0, invuln=0, win=0, lose=0.
REQ-040 On reset, the grace counter, edge register and frame semaphore SHALL clear.
REQ-041 Reset SHALL dominate new_game and all other inputs.
REQ-042 Reset asserted mid-GRACE or mid-PLAY SHALL abort the game with no death_pulse.

Verification
REQ-043 new_game, then 12 coin_pulses -> score_bcd=0x012, coins_left=52, state PLAY.
REQ-044 Score 0x099 plus one coin -> 0x100; score 0x999 plus one coin -> remains 0x999.
REQ-045 monster_hit held high for 3 frames in PLAY -> exactly one death_pulse, lives 3->2, invuln=1 for 60 startOfFrame pulses, then PLAY.
REQ-046 Second hit during GRACE -> no death_pulse, lives unchanged.
REQ-047 Three separated hits -> lives reaches 0, lose=1, and later coin_pulses do not change score.
REQ-048 coins_left=1 with coin_pulse and a monster_hit rising edge in the same cycle -> win=1, lives unchanged, no death_pulse.
REQ-049 stop_gameN=0 with coin_pulses -> no change; reset pulsed in GRACE -> IDLE and all outputs at reset values next cycle.
